// File: rtl/notation_arbiter.sv
// Round-robin arbiter sharing one binary -> base-N notation converter between NUM_REQ requesters.
// Sequences converter reset/operand, routes its digits back, and aborts conversions that never finish.
module notation_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int BIT_DEPTH  = 8,
  parameter int NUM_DIGITS = 3,
  parameter int TIMEOUT    = 64
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*BIT_DEPTH-1:0]    req_number,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [NUM_DIGITS*BIT_DEPTH-1:0] rsp_digits,
  output logic                            rsp_timeout,
  output logic                            busy,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic                            conv_reset,
  output logic [BIT_DEPTH-1:0]            conv_number,
  input  logic [NUM_DIGITS*BIT_DEPTH-1:0] conv_digits,
  input  logic                            conv_done
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t                 state;
  logic [GW-1:0]          last_grant;
  logic [GW-1:0]          winner;
  logic [GW-1:0]          cand;
  logic                   found;
  logic [CW-1:0]          wait_cnt;
  logic [BIT_DEPTH-1:0]   req_num_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign req_num_arr[i] = req_number[i*BIT_DEPTH +: BIT_DEPTH];
  end

  // Search starts one past the last grant so every requester gets a turn.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    winner = last_grant;
    cand   = last_grant;
    found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GW'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && found) req_ready[winner] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      conv_reset  <= 1'b1;
      conv_number <= '0;
      rsp_valid   <= '0;
      rsp_digits  <= '0;
      rsp_timeout <= 1'b0;
      busy        <= 1'b0;
      grant_id    <= GW'(NUM_REQ - 1);
      last_grant  <= GW'(NUM_REQ - 1);
      wait_cnt    <= '0;
    end else begin
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            conv_number <= req_num_arr[winner];
            grant_id    <= winner;
            last_grant  <= winner;
            busy        <= 1'b1;
            state       <= START;
          end
        end
        // Converter stays in reset one cycle with the new operand already stable.
        START: begin
          wait_cnt   <= '0;
          conv_reset <= 1'b0;
          state      <= WAIT;
        end
        WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (conv_done) begin
            rsp_digits  <= conv_digits;
            rsp_timeout <= 1'b0;
            rsp_valid   <= ONE_HOT0 << grant_id;
            conv_reset  <= 1'b1;
            state       <= RESP;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            rsp_digits  <= '0;
            rsp_timeout <= 1'b1;
            rsp_valid   <= ONE_HOT0 << grant_id;
            conv_reset  <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_notation_arbiter.sv
// Directed bench for notation_arbiter with a behavioural base-10 converter and stall/instant stubs.
// Expected responses are queued at each accepted transfer and compared when rsp_valid pulses.
module tb_notation_arbiter;

  localparam int NR = 3;
  localparam int BD = 8;
  localparam int ND = 3;
  localparam int TO = 16;

  typedef enum logic [1:0] {C_REAL, C_STALL, C_IMMED} conv_mode_t;

  typedef struct {
    int            idx;
    logic [ND*BD-1:0] digits;
    logic          timeout;
    int            acc_edge;
    int            lat;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR*BD-1:0]  req_number;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     rsp_valid;
  logic [ND*BD-1:0]  rsp_digits;
  logic              rsp_timeout;
  logic              busy;
  logic [1:0]        grant_id;
  logic              conv_reset;
  logic [BD-1:0]     conv_number;
  logic [ND*BD-1:0]  conv_digits;
  logic              conv_done;

  conv_mode_t        conv_mode;
  logic [7:0]        conv_cnt;

  exp_t              sb[$];
  int                grants[$];
  int                pass_cnt = 0;
  int                chk_cnt  = 0;
  int                cyc      = 0;
  int                exp_last = NR - 1;
  int                busy_cycles = 0;
  logic [NR-1:0]     auto_drop;

  notation_arbiter #(.NUM_REQ(NR), .BIT_DEPTH(BD), .NUM_DIGITS(ND), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_number(req_number), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_digits(rsp_digits), .rsp_timeout(rsp_timeout),
    .busy(busy), .grant_id(grant_id),
    .conv_reset(conv_reset), .conv_number(conv_number),
    .conv_digits(conv_digits), .conv_done(conv_done)
  );

  always #5 clk = ~clk;

  function automatic logic [ND*BD-1:0] dec_digits(input logic [BD-1:0] n);
    return {8'(n / 100), 8'((n / 10) % 10), 8'(n % 10)};
  endfunction

  // Behavioural converter: counts while out of reset, done after 2 + n%4 cycles.
  always @(posedge clk) begin
    if (conv_reset) conv_cnt <= '0;
    else            conv_cnt <= conv_cnt + 8'd1;
  end

  assign conv_done = !conv_reset &&
                     (conv_mode == C_IMMED ||
                      (conv_mode == C_REAL && conv_cnt >= 8'(2 + conv_number % 4)));
  assign conv_digits = (conv_mode == C_IMMED) ? {8'd4, 8'd5, 8'd6} :
                       (conv_mode == C_STALL) ? 24'hAAAAAA : dec_digits(conv_number);

  function automatic logic [NR-1:0] rr_ready(input int last, input logic [NR-1:0] v);
    for (int k = 1; k <= NR; k++) begin
      int i = (last + k) % NR;
      if (v[i]) return NR'(1) << i;
    end
    return '0;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    assert (got === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic set_num(input int i, input logic [BD-1:0] n);
    req_number[i*BD +: BD] = n;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " rsp_valid"},   rsp_valid,   0);
    check({tag, " rsp_digits"},  rsp_digits,  0);
    check({tag, " rsp_timeout"}, rsp_timeout, 0);
    check({tag, " busy"},        busy,        0);
    check({tag, " grant_id"},    grant_id,    NR - 1);
    check({tag, " conv_reset"},  conv_reset,  1);
    check({tag, " conv_number"}, conv_number, 0);
  endtask

  // One clock: sample at negedge, record transfers and responses, drive after posedge.
  task automatic tick();
    logic [NR-1:0] xfer;
    exp_t e;
    @(negedge clk);
    check("req_ready", req_ready, busy ? '0 : rr_ready(exp_last, req_valid));
    xfer = req_valid & req_ready;
    for (int i = 0; i < NR; i++) begin
      if (xfer[i]) begin
        e.idx      = i;
        e.acc_edge = cyc + 1;
        case (conv_mode)
          C_STALL: begin e.digits = '0; e.timeout = 1'b1; e.lat = TO + 2; end
          C_IMMED: begin e.digits = {8'd4, 8'd5, 8'd6}; e.timeout = 1'b0; e.lat = 3; end
          default: begin
            e.digits  = dec_digits(req_number[i*BD +: BD]);
            e.timeout = 1'b0;
            e.lat     = 3 + 2 + int'(req_number[i*BD +: BD]) % 4;
          end
        endcase
        sb.push_back(e);
        grants.push_back(i);
        exp_last = i;
      end
    end
    if (rsp_valid != '0) begin
      if (sb.size() == 0) begin
        check("unexpected rsp_valid", rsp_valid, 0);
      end else begin
        e = sb.pop_front();
        check("rsp_valid",   rsp_valid,   NR'(1) << e.idx);
        check("rsp_digits",  rsp_digits,  e.digits);
        check("rsp_timeout", rsp_timeout, e.timeout);
        check("rsp grant_id", grant_id,   e.idx);
        check("latency",     cyc + 1 - e.acc_edge, e.lat);
      end
    end
    if (busy) busy_cycles++;
    @(posedge clk);
    cyc++;
    #1;
    req_valid = req_valid & ~(xfer & auto_drop);
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n = 0;
    while ((sb.size() != 0 || busy || req_valid != '0) && n < limit) begin
      tick();
      n++;
    end
    check({tag, " drained"}, (sb.size() == 0 && !busy), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    req_valid  = '0;
    req_number = '0;
    conv_mode  = C_REAL;
    auto_drop  = '1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    check("reset req_ready", req_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Three simultaneous requests from reset: grants 0,1,2.
    set_num(0, 8'd250); set_num(1, 8'd7); set_num(2, 8'd99);
    req_valid = 3'b111;
    grants.delete();
    wait_idle("simul", 100);
    check("simul grant count", grants.size(), 3);
    for (int i = 0; i < 3; i++) check("simul grant order", grants[i], i);

    // Fairness: req0 and req1 held continuously, req2 idle.
    auto_drop = '0;
    set_num(0, 8'd42); set_num(1, 8'd13);
    req_valid = 3'b011;
    grants.delete();
    for (int n = 0; n < 200 && grants.size() < 4; n++) tick();
    req_valid = '0;
    auto_drop = '1;
    wait_idle("fair", 60);
    check("fair grant count", grants.size(), 4);
    for (int i = 0; i < 4 && i < grants.size(); i++) check("fair grant order", grants[i], i % 2);

    // Single request.
    set_num(0, 8'd123);
    req_valid = 3'b001;
    grants.delete();
    wait_idle("single", 40);
    check("single accept count", grants.size(), 1);

    // Converter never finishes: timeout response.
    conv_mode = C_STALL;
    set_num(1, 8'd55);
    req_valid = 3'b010;
    wait_idle("timeout", 60);

    // Converter done in the first WAIT cycle: minimum latency, busy for 3 cycles.
    conv_mode = C_IMMED;
    set_num(2, 8'd200);
    req_valid = 3'b100;
    busy_cycles = 0;
    wait_idle("fast", 20);
    check("fast busy cycles", busy_cycles, 3);

    // Reset while waiting on the converter.
    conv_mode = C_STALL;
    set_num(0, 8'd77);
    req_valid = 3'b001;
    for (int n = 0; n < 10 && !(busy && !conv_reset); n++) tick();
    check("in WAIT before reset", (busy && !conv_reset), 1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("mid reset");
    sb.delete();
    exp_last = NR - 1;
    req_valid = '0;
    repeat (3) tick();
    @(negedge clk);
    reset = 1'b0;
    conv_mode = C_REAL;
    @(posedge clk);
    #1;
    set_num(0, 8'd12); set_num(1, 8'd34);
    req_valid = 3'b011;
    grants.delete();
    wait_idle("post reset", 60);
    check("post reset grant count", grants.size(), 2);
    if (grants.size() >= 2) begin
      check("post reset first grant", grants[0], 0);
      check("post reset second grant", grants[1], 1);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
